// File: rtl/alg_amba_vip_fault_inj_burst.sv
// Stream fault injector: FWFT beat FIFO, ID-filtered burst faults, status FSM.
// Optional ALG_FAULT_STATS_EN builds the nberror/nbrequest statistics counters.
module alg_amba_vip_fault_inj_burst #(
    parameter int DATA_WIDTH      = 128,
    parameter int FAULT_WIDTH     = 128,
    parameter int ID_WIDTH        = 4,
    parameter int FIFO_LOG2_DEPTH = 2,
    parameter int NUM_ID_SLOTS    = 2
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             restart,
    input  logic [19:0]                      seed,
    input  logic [19:0]                      prob_thres,
    input  logic [FAULT_WIDTH-1:0]           reg_pattern,
    input  logic [3:0]                       cmd,
    input  logic [NUM_ID_SLOTS*ID_WIDTH-1:0] id_match,
    input  logic [NUM_ID_SLOTS-1:0]          id_match_en,
    input  logic [7:0]                       burst_len,
    input  logic [15:0]                      holdoff,
    input  logic [31:0]                      max_errors,
    output logic [2:0]                       fsm_state,
    output logic [31:0]                      stats_lfsr,
    output logic [31:0]                      stats_nberror,
    output logic [31:0]                      stats_nbrequest,
    input  logic [ID_WIDTH-1:0]              s_id,
    input  logic [DATA_WIDTH-1:0]            s_data,
    input  logic                             s_valid,
    output logic                             s_ready,
    output logic [ID_WIDTH-1:0]              m_id,
    output logic [DATA_WIDTH-1:0]            m_data,
    output logic                             m_valid,
    input  logic                             m_ready
);

    localparam int L     = $clog2(FAULT_WIDTH);
    localparam int DEPTH = 1 << FIFO_LOG2_DEPTH;
    localparam int AW    = FIFO_LOG2_DEPTH;
    localparam logic [AW:0]  FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [L-1:0] BYTE_LSB = L'(7);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_BURST = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    logic [ID_WIDTH-1:0]   mem_id   [DEPTH];
    logic [DATA_WIDTH-1:0] mem_data [DEPTH];
    logic [AW-1:0]         wptr, rptr;
    logic [AW:0]           count;
    logic                  wr, rd;

    state_t           state;
    logic [19:0]      lfsr;
    logic [3:0]       sh_cmd;
    logic [FAULT_WIDTH-1:0] sh_pat;
    logic [19:0]      sh_thres;
    logic [7:0]       sh_blen;
    logic [15:0]      sh_hold;
    logic [31:0]      sh_max;
    logic [7:0]       rem;
    logic [15:0]      cnt;
    logic [31:0]      err_cnt;

    logic [DATA_WIDTH-1:0]  raw;
    logic                   match, fault, hit, cap_hit;
    logic [L-1:0]           id1, id2, lo, hi, b1, b2;
    logic [FAULT_WIDTH-1:0] mask, fw, fc;

    assign s_ready = (count != FULL_CNT);
    assign m_valid = (count != '0);
    assign wr      = s_valid && s_ready;
    assign rd      = m_valid && m_ready;
    assign m_id    = mem_id[rptr];
    assign raw     = mem_data[rptr];

    always_ff @(posedge clk) begin
        if (wr) begin
            mem_id[wptr]   <= s_id;
            mem_data[wptr] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr) wptr <= wptr + 1'b1;
            if (rd) rptr <= rptr + 1'b1;
            if (wr && !rd)      count <= count + 1'b1;
            else if (rd && !wr) count <= count - 1'b1;
        end
    end

    always_comb begin
        match = 1'b0;
        for (int k = 0; k < NUM_ID_SLOTS; k++)
            if (id_match_en[k] && id_match[k*ID_WIDTH +: ID_WIDTH] == m_id)
                match = 1'b1;
    end

    assign fault = match && !restart &&
                   (state == S_BURST || (state == S_ARMED && lfsr < sh_thres));
    assign hit     = rd && match && !restart;
    assign cap_hit = (sh_max != '0) && (err_cnt + 32'd1 == sh_max);

    assign id1 = lfsr[L-1:0];
    assign id2 = lfsr[19 -: L];
    assign lo  = (id1 < id2) ? id1 : id2;
    assign hi  = (id1 < id2) ? id2 : id1;
    assign b1  = id1 & ~BYTE_LSB;
    assign b2  = id2 & ~BYTE_LSB;
    assign fw  = raw[FAULT_WIDTH-1:0];

    always_comb begin
        mask = '0;
        for (int i = 0; i < FAULT_WIDTH; i++)
            mask[i] = (L'(i) >= lo) && (L'(i) <= hi);
    end

    always_comb begin
        fc = fw;
        unique case (sh_cmd)
            4'h1: fc = fw ^ sh_pat;
            4'h2: fc = fw & sh_pat;
            4'h3: fc = fw | sh_pat;
            4'h4: fc = fw ^ (sh_pat & mask);
            4'h5: fc = fw & (sh_pat | ~mask);
            4'h6: fc = fw | (sh_pat & mask);
            4'h7: fc = ~fw;
            4'h8: fc = fw ^ mask;
            4'h9: begin
                fc[id1] = fw[id2];
                fc[id2] = fw[id1];
            end
            4'hA: begin
                fc[b1 +: 8] = fw[b2 +: 8];
                fc[b2 +: 8] = fw[b1 +: 8];
            end
            default: fc = fw;
        endcase
    end

    always_comb begin
        m_data = raw;
        if (fault) m_data[FAULT_WIDTH-1:0] = fc;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            lfsr     <= '0;
            sh_cmd   <= '0;
            sh_pat   <= '0;
            sh_thres <= '0;
            sh_blen  <= '0;
            sh_hold  <= '0;
            sh_max   <= '0;
            rem      <= '0;
            cnt      <= '0;
            err_cnt  <= '0;
        end else if (restart) begin
            state    <= S_ARMED;
            lfsr     <= (seed == '0) ? 20'h00001 : seed;
            sh_cmd   <= cmd;
            sh_pat   <= reg_pattern;
            sh_thres <= prob_thres;
            sh_blen  <= burst_len;
            sh_hold  <= holdoff;
            sh_max   <= max_errors;
            rem      <= '0;
            cnt      <= '0;
            err_cnt  <= '0;
        end else if (hit) begin
            if (state == S_ARMED || state == S_BURST || state == S_HOLD)
                lfsr <= {lfsr[18:0], lfsr[19] ^ lfsr[16]};
            unique case (state)
                S_ARMED: if (fault) begin
                    err_cnt <= err_cnt + 32'd1;
                    if (cap_hit) begin
                        state <= S_DONE;
                    end else if (sh_blen > 8'd1) begin
                        state <= S_BURST;
                        rem   <= sh_blen - 8'd1;
                    end else if (sh_hold != '0) begin
                        state <= S_HOLD;
                        cnt   <= sh_hold;
                    end
                end
                S_BURST: begin
                    err_cnt <= err_cnt + 32'd1;
                    rem     <= rem - 8'd1;
                    if (cap_hit) begin
                        state <= S_DONE;
                    end else if (rem == 8'd1) begin
                        if (sh_hold != '0) begin
                            state <= S_HOLD;
                            cnt   <= sh_hold;
                        end else begin
                            state <= S_ARMED;
                        end
                    end
                end
                S_HOLD: begin
                    cnt <= cnt - 16'd1;
                    if (cnt == 16'd1) state <= S_ARMED;
                end
                default: ;
            endcase
        end
    end

    assign fsm_state  = state;
    assign stats_lfsr = {12'b0, lfsr};

`ifdef ALG_FAULT_STATS_EN
    logic [31:0] req_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            req_cnt <= '0;
        else if (restart)
            req_cnt <= '0;
        else if (rd && state != S_IDLE)
            req_cnt <= req_cnt + 32'd1;
    end

    assign stats_nberror   = err_cnt;
    assign stats_nbrequest = req_cnt;
`else
    assign stats_nberror   = '0;
    assign stats_nbrequest = '0;
`endif

endmodule

// File: tb/tb_alg_amba_vip_fault_inj_burst.sv
// Directed bench for alg_amba_vip_fault_inj_burst (default parameters).
module tb_alg_amba_vip_fault_inj_burst;

`ifdef ALG_FAULT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rstn, restart;
    logic [19:0]  seed, prob_thres;
    logic [127:0] reg_pattern;
    logic [3:0]   cmd;
    logic [7:0]   id_match;
    logic [1:0]   id_match_en;
    logic [7:0]   burst_len;
    logic [15:0]  holdoff;
    logic [31:0]  max_errors;
    logic [2:0]   fsm_state;
    logic [31:0]  stats_lfsr, stats_nberror, stats_nbrequest;
    logic [3:0]   s_id, m_id;
    logic [127:0] s_data, m_data;
    logic         s_valid, s_ready, m_valid, m_ready;

    int errors = 0;
    int checks = 0;

    alg_amba_vip_fault_inj_burst dut (
        .clk(clk), .rstn(rstn), .restart(restart), .seed(seed),
        .prob_thres(prob_thres), .reg_pattern(reg_pattern), .cmd(cmd),
        .id_match(id_match), .id_match_en(id_match_en),
        .burst_len(burst_len), .holdoff(holdoff), .max_errors(max_errors),
        .fsm_state(fsm_state), .stats_lfsr(stats_lfsr),
        .stats_nberror(stats_nberror), .stats_nbrequest(stats_nbrequest),
        .s_id(s_id), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_id(m_id), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic do_restart(input logic [19:0] sd, input logic [19:0] thr,
                              input logic [3:0] c, input logic [127:0] pat,
                              input logic [7:0] bl, input logic [15:0] ho,
                              input logic [31:0] mx);
        @(negedge clk);
        seed = sd; prob_thres = thr; cmd = c; reg_pattern = pat;
        burst_len = bl; holdoff = ho; max_errors = mx; restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        // scramble live config to show it is ignored after capture
        cmd = 4'h0; prob_thres = '0; reg_pattern = '0;
        burst_len = 8'd0; holdoff = 16'd0; max_errors = 32'd0;
    endtask

    task automatic send(input logic [3:0] id, input logic [127:0] d,
                        output logic v, output logic [127:0] obs);
        @(negedge clk);
        s_id = id; s_data = d; s_valid = 1'b1; m_ready = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        v = m_valid;
        obs = m_data;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; restart = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
        s_id = '0; s_data = '0; seed = '0; prob_thres = '0;
        reg_pattern = '0; cmd = '0; id_match = {4'd5, 4'd3};
        id_match_en = 2'b01; burst_len = '0; holdoff = '0; max_errors = '0;
        @(posedge clk); #1;
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_hs: m_valid=%b s_ready=%b expected 0/1", m_valid, s_ready);
        end
        checks++;
        if (fsm_state !== 3'd0 || stats_lfsr !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: fsm=%0d lfsr=%h expected 0/0", fsm_state, stats_lfsr);
        end
        checks++;
        if (stats_nberror !== 32'd0 || stats_nbrequest !== 32'd0) begin
            errors++;
            $display("FAIL reset_stats: nberr=%0d nbreq=%0d expected 0/0", stats_nberror, stats_nbrequest);
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_idle_passthrough();
        logic v;
        logic [127:0] obs, d;
        cmd = 4'h1; reg_pattern = '1; prob_thres = 20'hFFFFF;
        for (int i = 0; i < 4; i++) begin
            d = 128'hA5A5_0000 + 128'(i);
            send(4'd3, d, v, obs);
            checks++;
            if (v !== 1'b1 || obs !== d) begin
                errors++;
                $display("FAIL idle_beat%0d: got %h expected %h", i, obs, d);
            end
        end
        checks++;
        if (fsm_state !== 3'd0 || stats_nbrequest !== 32'd0) begin
            errors++;
            $display("FAIL idle_state: fsm=%0d nbreq=%0d expected 0/0", fsm_state, stats_nbrequest);
        end
    endtask

    task automatic test_invert();
        logic v;
        logic [127:0] obs, d;
        do_restart(20'h0, 20'hFFFFF, 4'h7, '0, 8'd1, 16'd0, 32'd0);
        checks++;
        if (stats_lfsr !== 32'd1) begin
            errors++;
            $display("FAIL inv_seed: lfsr=%h expected 1", stats_lfsr);
        end
        for (int i = 0; i < 3; i++) begin
            d = 128'h0123_4567_89AB_CDEF_0000_1111_2222_0000 + 128'(i);
            send(4'd3, d, v, obs);
            checks++;
            if (v !== 1'b1 || obs !== ~d) begin
                errors++;
                $display("FAIL inv_beat%0d: got %h expected %h", i, obs, ~d);
            end
        end
        checks++;
        if (stats_lfsr !== 32'd8 || fsm_state !== 3'd1) begin
            errors++;
            $display("FAIL inv_lfsr: lfsr=%h fsm=%0d expected 8/1", stats_lfsr, fsm_state);
        end
        checks++;
        if (stats_nberror !== (STATS ? 32'd3 : 32'd0) ||
            stats_nbrequest !== (STATS ? 32'd3 : 32'd0)) begin
            errors++;
            $display("FAIL inv_stats: nberr=%0d nbreq=%0d", stats_nberror, stats_nbrequest);
        end
    endtask

    task automatic test_burst();
        logic v;
        logic [127:0] obs, d, e;
        logic [9:0] flt = 10'b00_1110_0111;
        logic [2:0] st [10] = '{3'd2, 3'd2, 3'd3, 3'd3, 3'd1,
                                3'd2, 3'd2, 3'd3, 3'd3, 3'd1};
        do_restart(20'h0, 20'hFFFFF, 4'h7, '0, 8'd3, 16'd2, 32'd0);
        for (int i = 0; i < 10; i++) begin
            d = 128'hFACE_0000 + 128'(i);
            e = flt[i] ? ~d : d;
            send(4'd3, d, v, obs);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL burst_beat%0d: got %h expected %h", i + 1, obs, e);
            end
            checks++;
            if (fsm_state !== st[i]) begin
                errors++;
                $display("FAIL burst_state%0d: got %0d expected %0d", i + 1, fsm_state, st[i]);
            end
        end
    endtask

    task automatic test_cap();
        logic v;
        logic [127:0] obs, d, e;
        do_restart(20'h0, 20'hFFFFF, 4'h7, '0, 8'd1, 16'd0, 32'd2);
        for (int i = 0; i < 5; i++) begin
            d = 128'h7700 + 128'(i);
            e = (i < 2) ? ~d : d;
            send(4'd3, d, v, obs);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL cap_beat%0d: got %h expected %h", i + 1, obs, e);
            end
        end
        checks++;
        if (fsm_state !== 3'd4 || stats_nberror !== (STATS ? 32'd2 : 32'd0)) begin
            errors++;
            $display("FAIL cap_end: fsm=%0d nberr=%0d", fsm_state, stats_nberror);
        end
    endtask

    task automatic test_id_filter();
        logic v;
        logic [127:0] obs, d, e;
        logic [3:0] ids [3] = '{4'd3, 4'd5, 4'd3};
        do_restart(20'h0, 20'hFFFFF, 4'h7, '0, 8'd1, 16'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            d = 128'hBEEF_0000 + 128'(i);
            e = (ids[i] == 4'd3) ? ~d : d;
            send(ids[i], d, v, obs);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL id_beat%0d: got %h expected %h", i, obs, e);
            end
        end
        checks++;
        if (stats_lfsr !== 32'd4 || stats_nbrequest !== (STATS ? 32'd3 : 32'd0)) begin
            errors++;
            $display("FAIL id_end: lfsr=%h nbreq=%0d expected 4", stats_lfsr, stats_nbrequest);
        end
    endtask

    task automatic test_modes();
        logic v;
        logic [127:0] obs;
        logic [19:0]  sd  [7] = '{20'd8, 20'd8, 20'd8, 20'd1, 20'd1, 20'd1, 20'd1};
        logic [19:0]  th  [7] = '{20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF,
                                  20'hFFFFF, 20'hFFFFF, 20'h0};
        logic [3:0]   cm  [7] = '{4'h9, 4'hA, 4'h8, 4'h4, 4'h5, 4'h2, 4'h7};
        logic [127:0] pt  [7] = '{128'h0, 128'h0, 128'h0, '1, 128'h0, 128'hF0, 128'h0};
        logic [127:0] din [7] = '{128'h1, 128'h1234, 128'h0, 128'h0,
                                  128'hFF, 128'hFF, 128'h5};
        logic [127:0] exp [7] = '{128'h100, 128'h3412, 128'h1FF, 128'h3,
                                  128'hFC, 128'hF0, 128'h5};
        for (int i = 0; i < 7; i++) begin
            do_restart(sd[i], th[i], cm[i], pt[i], 8'd1, 16'd0, 32'd0);
            send(4'd3, din[i], v, obs);
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL mode_cmd%h: got %h expected %h", cm[i], obs, exp[i]);
            end
        end
        checks++;
        if (fsm_state !== 3'd1) begin
            errors++;
            $display("FAIL mode_nofault_state: fsm=%0d expected 1", fsm_state);
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] d0 = 128'hC0DE_0000;
        do_restart(20'h0, 20'hFFFFF, 4'h7, '0, 8'd1, 16'd0, 32'd0);
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s_id = 4'd3; s_data = d0 + 128'(i); s_valid = 1'b1;
        end
        @(negedge clk);
        s_valid = 1'b0;
        checks++;
        if (s_ready !== 1'b0 || m_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_full: s_ready=%b m_valid=%b expected 0/1", s_ready, m_valid);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (m_data !== ~d0) begin
                errors++;
                $display("FAIL bp_hold%0d: got %h expected %h", i, m_data, ~d0);
            end
            @(negedge clk);
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || fsm_state !== 3'd0) begin
            errors++;
            $display("FAIL bp_async_rst: m_valid=%b s_ready=%b fsm=%0d", m_valid, s_ready, fsm_state);
        end
        @(negedge clk);
        rstn = 1'b1;
        m_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_idle_passthrough();
        test_invert();
        test_burst();
        test_cap();
        test_id_filter();
        test_modes();
        test_backpressure();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
